debug_ctrlr: RTL and testbench
==============================

DEBUG_CTRLR -- requirements
Module: debug_ctrlr

Interface
REQ-001 Parameter ACK_TIMEOUT, default 255: max cycles to wait for acc_ack before an access is flagged as an error.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 cmd  input  4  command code from serial driver, sampled when out_valid=1.
REQ-005 addr  input  32  memory byte address or register index, sampled with cmd.
REQ-006 d_in  input  32  write data, sampled with cmd.
REQ-007 out_valid  input  1  one-cycle command strobe from serial driver.
REQ-008 busy  output  1  command in progress; low means d_rd/error are valid.
REQ-009 d_rd  output  32  reply word to serial driver.
REQ-010 error  output  1  last command failed; held until the next command is accepted.
REQ-011 mcu_pause  output  1  level request for the MCU to halt.
REQ-012 mcu_paused  input  1  MCU acknowledge that it is halted.
REQ-013 mcu_reset  output  1  one-cycle MCU reset pulse.
REQ-014 acc_rd  output  1  one-cycle read strobe to the MCU access port.
REQ-015 acc_wr  output  1  one-cycle write strobe to the MCU access port.
REQ-016 acc_rf  output  1  1 = register-file access, 0 = memory access.
REQ-017 acc_size  output  2  0 = byte, 2 = word.
REQ-018 acc_addr  output  32  access address; for register access, addr[4:0] zero-extended.
REQ-019 acc_wdata  output  32  write data.
REQ-020 acc_rdata  input  32  read data, valid when acc_ack=1.
REQ-021 acc_ack  input  1  one-cycle access completion.

Function
REQ-022 Command codes: 0x1 PAUSE, 0x2 RESUME, 0x3 MCU_RESET, 0x4 STATUS, 0x5 REG_RD, 0x6 REG_WR, 0xA MEM_RD_WORD, 0xB MEM_RD_BYTE, 0xC MEM_WR_WORD, 0xD MEM_WR_BYTE; any other code completes with error=1, d_rd=0.
REQ-023 States: S_IDLE, S_PAUSE_WAIT, S_ACCESS, S_ACK_WAIT, S_RESUME, S_DONE.
REQ-024 In S_IDLE, out_valid=1 latches cmd/addr/d_in, clears error, and sets busy=1 from the next cycle; busy stays 1 until S_DONE.
REQ-025 out_valid while busy=1 is ignored.
REQ-026 PAUSE: set mcu_pause=1, wait in S_PAUSE_WAIT for mcu_paused=1, then reply d_rd=1.
REQ-027 RESUME: clear mcu_pause, reply d_rd=0; no wait.
REQ-028 MCU_RESET: pulse mcu_reset for one cycle; mcu_pause keeps its value; reply d_rd=0.
REQ-029 STATUS: reply d_rd={30'b0, mcu_pause, mcu_paused}.
REQ-030 Accesses require mcu_paused=1; in S_ACCESS, drive a one-cycle acc_rd or acc_wr, then wait in S_ACK_WAIT.
REQ-031 On acc_ack: reads reply acc_rdata (byte reads zero-extend acc_rdata[7:0]); writes reply d_in.
REQ-032 Word accesses with addr[1:0] != 0 complete with error=1 and no strobe issued.
REQ-033 If acc_ack has not arrived after ACK_TIMEOUT cycles in S_ACK_WAIT: error=1, d_rd=0.
REQ-034 acc_ack arriving in the same cycle the timeout expires counts as success.
REQ-035 S_DONE lasts one cycle: busy=0 with d_rd/error valid, then returns to S_IDLE; minimum latency is out_valid to busy low in 3 cycles.
REQ-036 mcu_paused dropping mid-access does not abort the access.

Reset
REQ-037 Reset asserted (reset=0): all outputs 0, state S_IDLE, latched fields and timeout counter cleared.
REQ-038 Reset mid-command abandons the command without emitting a reply; busy=0 takes effect immediately.

Configuration
REQ-039 With DB_AUTO_PAUSE_EN defined, an access while mcu_pause=0 first pauses the MCU (S_PAUSE_WAIT), performs the access, then clears mcu_pause in S_RESUME before S_DONE.
REQ-040 Without DB_AUTO_PAUSE_EN, an access while mcu_paused=0 completes immediately with error=1, d_rd=0, and no strobe.

Verification
REQ-041 PAUSE with mcu_paused raised 5 cycles later -> mcu_pause=1, busy held for those cycles, d_rd=1, error=0.
REQ-042 Paused, MEM_RD_BYTE addr=0x100, acc_rdata=0xAABBCCDD acked after 2 cycles -> acc_rd pulse, acc_size=0, d_rd=0x000000DD.
REQ-043 Paused, MEM_WR_WORD addr=0x102 -> no acc_wr pulse, error=1, d_rd=0.
REQ-044 Paused, REG_RD addr=0x25, acc_ack never asserted -> acc_addr=0x5, acc_rf=1, error=1 after 255 cycles.
REQ-045 Running, REG_WR with macro defined -> pause, acc_wr, mcu_pause cleared, error=0; with macro undefined -> error=1, no strobe.
REQ-046 cmd=0x7 -> error=1; reset=0 during S_ACK_WAIT -> busy=0, mcu_pause=0, next command accepted normally.

Source files
------------

// File: rtl/debug_ctrlr.sv
// rtl/debug_ctrlr.sv - debug command controller between a serial driver and an MCU access port
//
// Accepts one command strobe at a time from the serial driver. It can pause,
// resume or reset the MCU, report status, or perform register-file and memory
// reads and writes through the MCU access port. The reply word and error flag
// are valid whenever busy is low.
//
// Parameter:
//   ACK_TIMEOUT  number of S_ACK_WAIT cycles allowed for acc_ack (default 255)
//
// Build option:
//   DB_AUTO_PAUSE_EN  when defined, an access issued while the MCU runs pauses
//                     it first and releases it afterwards; when undefined, such
//                     an access fails with error=1
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   cmd, addr, d_in, out_valid command strobe and its fields from the serial driver
//   busy, d_rd, error          command status and reply to the serial driver
//   mcu_pause, mcu_paused      halt request / halt acknowledge
//   mcu_reset                  one-cycle MCU reset pulse
//   acc_rd, acc_wr             one-cycle access strobes
//   acc_rf, acc_size           register-file select, 0=byte / 2=word
//   acc_addr, acc_wdata        access address and write data
//   acc_rdata, acc_ack         read data and completion from the access port

module debug_ctrlr #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  cmd,
  input  logic [31:0] addr,
  input  logic [31:0] d_in,
  input  logic        out_valid,
  output logic        busy,
  output logic [31:0] d_rd,
  output logic        error,
  output logic        mcu_pause,
  input  logic        mcu_paused,
  output logic        mcu_reset,
  output logic        acc_rd,
  output logic        acc_wr,
  output logic        acc_rf,
  output logic [1:0]  acc_size,
  output logic [31:0] acc_addr,
  output logic [31:0] acc_wdata,
  input  logic [31:0] acc_rdata,
  input  logic        acc_ack
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_PAUSE_WAIT = 3'd1;
  localparam logic [2:0] S_ACCESS     = 3'd2;
  localparam logic [2:0] S_ACK_WAIT   = 3'd3;
  localparam logic [2:0] S_RESUME     = 3'd4;
  localparam logic [2:0] S_DONE       = 3'd5;

  localparam logic [3:0] CMD_PAUSE   = 4'h1;
  localparam logic [3:0] CMD_RESUME  = 4'h2;
  localparam logic [3:0] CMD_RESET   = 4'h3;
  localparam logic [3:0] CMD_STATUS  = 4'h4;
  localparam logic [3:0] CMD_REG_RD  = 4'h5;
  localparam logic [3:0] CMD_REG_WR  = 4'h6;
  localparam logic [3:0] CMD_MRD_W   = 4'hA;
  localparam logic [3:0] CMD_MRD_B   = 4'hB;
  localparam logic [3:0] CMD_MWR_W   = 4'hC;
  localparam logic [3:0] CMD_MWR_B   = 4'hD;

  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(ACK_TIMEOUT - 1);

  logic [2:0]    state;
  logic [3:0]    cmd_q;
  logic [31:0]   addr_q;
  logic [31:0]   din_q;
  logic [TW-1:0] tcnt;
  // auto_resume: this command paused a running MCU and must release it.
  // clear_pause: a RESUME command drops mcu_pause in S_RESUME.
  logic          auto_resume;
  logic          clear_pause;

  logic is_access;
  logic is_rd;
  logic is_byte;
  logic is_reg;
  logic misaligned;

  always_comb begin
    is_access = 1'b0;
    is_rd     = 1'b0;
    is_byte   = 1'b0;
    is_reg    = 1'b0;
    case (cmd_q)
      CMD_REG_RD: begin is_access = 1'b1; is_rd = 1'b1; is_reg = 1'b1; end
      CMD_REG_WR: begin is_access = 1'b1; is_reg = 1'b1; end
      CMD_MRD_W:  begin is_access = 1'b1; is_rd = 1'b1; end
      CMD_MRD_B:  begin is_access = 1'b1; is_rd = 1'b1; is_byte = 1'b1; end
      CMD_MWR_W:  begin is_access = 1'b1; end
      CMD_MWR_B:  begin is_access = 1'b1; is_byte = 1'b1; end
      default:    begin end
    endcase
    // Register indices are not byte addresses, so alignment only applies to memory words.
    misaligned = is_access && !is_reg && !is_byte && (addr_q[1:0] != 2'b00);
  end

  // Derived from state so that an asynchronous reset drops busy at once.
  assign busy = (state != S_IDLE) && (state != S_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      cmd_q       <= 4'h0;
      addr_q      <= 32'h0;
      din_q       <= 32'h0;
      tcnt        <= '0;
      auto_resume <= 1'b0;
      clear_pause <= 1'b0;
      d_rd        <= 32'h0;
      error       <= 1'b0;
      mcu_pause   <= 1'b0;
      mcu_reset   <= 1'b0;
      acc_rd      <= 1'b0;
      acc_wr      <= 1'b0;
      acc_rf      <= 1'b0;
      acc_size    <= 2'd0;
      acc_addr    <= 32'h0;
      acc_wdata   <= 32'h0;
    end else begin
      // Strobes and the reset pulse are single-cycle by construction.
      acc_rd    <= 1'b0;
      acc_wr    <= 1'b0;
      mcu_reset <= 1'b0;

      case (state)
        S_IDLE: begin
          if (out_valid) begin
            cmd_q       <= cmd;
            addr_q      <= addr;
            din_q       <= d_in;
            error       <= 1'b0;
            auto_resume <= 1'b0;
            clear_pause <= 1'b0;
            state       <= S_ACCESS;
          end
        end

        // Decode and dispatch; also re-entered after an automatic pause completes.
        S_ACCESS: begin
          case (cmd_q)
            CMD_PAUSE: begin
              mcu_pause <= 1'b1;
              state     <= S_PAUSE_WAIT;
            end
            CMD_RESUME: begin
              clear_pause <= 1'b1;
              d_rd        <= 32'h0;
              state       <= S_RESUME;
            end
            CMD_RESET: begin
              mcu_reset <= 1'b1;
              d_rd      <= 32'h0;
              state     <= S_RESUME;
            end
            CMD_STATUS: begin
              d_rd  <= {30'b0, mcu_pause, mcu_paused};
              state <= S_RESUME;
            end
            default: begin
              if (!is_access || misaligned) begin
                error <= 1'b1;
                d_rd  <= 32'h0;
                state <= S_RESUME;
              end else if (!mcu_paused) begin
`ifdef DB_AUTO_PAUSE_EN
                // Only release the MCU afterwards if we were the ones to pause it.
                if (!mcu_pause) auto_resume <= 1'b1;
                mcu_pause <= 1'b1;
                state     <= S_PAUSE_WAIT;
`else
                error <= 1'b1;
                d_rd  <= 32'h0;
                state <= S_RESUME;
`endif
              end else begin
                acc_rd    <= is_rd;
                acc_wr    <= !is_rd;
                acc_rf    <= is_reg;
                acc_size  <= is_byte ? 2'd0 : 2'd2;
                acc_addr  <= is_reg ? {27'b0, addr_q[4:0]} : addr_q;
                acc_wdata <= din_q;
                tcnt      <= '0;
                state     <= S_ACK_WAIT;
              end
            end
          endcase
        end

        S_PAUSE_WAIT: begin
          if (mcu_paused) begin
            if (cmd_q == CMD_PAUSE) begin
              d_rd  <= 32'h1;
              state <= S_DONE;
            end else begin
              state <= S_ACCESS;
            end
          end
        end

        // mcu_paused is deliberately not watched here: an issued access runs to completion.
        S_ACK_WAIT: begin
          if (acc_ack) begin
            if (!is_rd)       d_rd <= din_q;
            else if (is_byte) d_rd <= {24'b0, acc_rdata[7:0]};
            else              d_rd <= acc_rdata;
            state <= auto_resume ? S_RESUME : S_DONE;
          end else if (tcnt == T_LAST) begin
            error <= 1'b1;
            d_rd  <= 32'h0;
            state <= auto_resume ? S_RESUME : S_DONE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        S_RESUME: begin
          if (clear_pause || auto_resume) mcu_pause <= 1'b0;
          state <= S_DONE;
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_ctrlr.sv
// tb/tb_debug_ctrlr.sv - directed self-checking bench for debug_ctrlr

module tb_debug_ctrlr;

  logic        clk;
  logic        reset;
  logic [3:0]  cmd;
  logic [31:0] addr;
  logic [31:0] d_in;
  logic        out_valid;
  logic        busy;
  logic [31:0] d_rd;
  logic        error;
  logic        mcu_pause;
  logic        mcu_paused;
  logic        mcu_reset;
  logic        acc_rd;
  logic        acc_wr;
  logic        acc_rf;
  logic [1:0]  acc_size;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [31:0] acc_rdata;
  logic        acc_ack;

  debug_ctrlr #(.ACK_TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .cmd(cmd), .addr(addr), .d_in(d_in),
    .out_valid(out_valid), .busy(busy), .d_rd(d_rd), .error(error),
    .mcu_pause(mcu_pause), .mcu_paused(mcu_paused), .mcu_reset(mcu_reset),
    .acc_rd(acc_rd), .acc_wr(acc_wr), .acc_rf(acc_rf), .acc_size(acc_size),
    .acc_addr(acc_addr), .acc_wdata(acc_wdata), .acc_rdata(acc_rdata),
    .acc_ack(acc_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Access-port and MCU model: ack_delay=0 means never acknowledge.
  int          ack_delay = 0;
  int          ack_cnt = 0;
  logic [31:0] ack_data = 32'h0;
  logic        paused_set = 1'b0;
  logic        follow = 1'b0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          rst_cnt = 0;
  logic [31:0] last_addr = 32'h0;
  logic [1:0]  last_size = 2'd3;
  logic        last_rf = 1'b0;
  logic [31:0] last_wdata = 32'h0;
  int          busy_cycles = 0;

  initial begin
    acc_ack    = 1'b0;
    acc_rdata  = 32'h0;
    mcu_paused = 1'b0;
  end

  always @(negedge clk) begin
    acc_ack    = 1'b0;
    mcu_paused = follow ? mcu_pause : paused_set;
    if (mcu_reset) rst_cnt++;
    if (acc_rd || acc_wr) begin
      if (acc_rd) rd_cnt++;
      if (acc_wr) wr_cnt++;
      last_addr  = acc_addr;
      last_size  = acc_size;
      last_rf    = acc_rf;
      last_wdata = acc_wdata;
    end
    if (ack_cnt > 0) begin
      ack_cnt--;
      if (ack_cnt == 0) begin
        acc_ack   = 1'b1;
        acc_rdata = ack_data;
      end
    end else if ((acc_rd || acc_wr) && ack_delay > 0) begin
      ack_cnt = ack_delay;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    cmd = c; addr = a; d_in = d; out_valid = 1'b1;
    @(negedge clk);
    out_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    busy_cycles = 1;
    while (busy === 1'b1 && busy_cycles < limit) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cycles++;
    end
    check({tag, "_done"}, {31'b0, busy}, 32'h0);
  endtask

  int rd0, wr0, rst0;

  initial begin
    reset = 1'b0; cmd = 4'h0; addr = 32'h0; d_in = 32'h0; out_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_d_rd", d_rd, 32'h0);
    check("rst_error", {31'b0, error}, 32'h0);
    check("rst_pause", {31'b0, mcu_pause}, 32'h0);
    check("rst_strobes", {29'b0, mcu_reset, acc_rd, acc_wr}, 32'h0);
    check("rst_acc_addr", acc_addr, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // PAUSE, acknowledge 5 cycles later; a strobe while busy must be ignored
    issue(4'h1, 32'h0, 32'h0);
    check("pause_busy", {31'b0, busy}, 32'h1);
    @(negedge clk);
    check("pause_req", {31'b0, mcu_pause}, 32'h1);
    cmd = 4'h7; out_valid = 1'b1;
    @(negedge clk);
    out_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("pause_busy_held", {31'b0, busy}, 32'h1);
    paused_set = 1'b1;
    wait_done("pause", 50);
    check("pause_d_rd", d_rd, 32'h1);
    check("pause_error", {31'b0, error}, 32'h0);
    @(negedge clk);
    check("pause_no_extra", {31'b0, busy}, 32'h0);

    // STATUS while paused
    issue(4'h4, 32'h0, 32'h0);
    wait_done("status_p", 20);
    check("status_p_d_rd", d_rd, 32'h3);
    check("status_p_lat", busy_cycles, 2);

    // MEM_RD_BYTE 0x100, ack after 2 cycles
    rd0 = rd_cnt; ack_delay = 2; ack_data = 32'hAABBCCDD;
    issue(4'hB, 32'h100, 32'h0);
    wait_done("rdb", 50);
    check("rdb_strobe", rd_cnt - rd0, 1);
    check("rdb_size", {30'b0, last_size}, 32'h0);
    check("rdb_addr", last_addr, 32'h100);
    check("rdb_d_rd", d_rd, 32'h000000DD);
    check("rdb_error", {31'b0, error}, 32'h0);
    check("rdb_lat", busy_cycles, 4);

    // MEM_RD_WORD 0x104; mcu_paused drops mid-access
    ack_delay = 3; ack_data = 32'h12345678;
    issue(4'hA, 32'h104, 32'h0);
    @(negedge clk);
    paused_set = 1'b0;
    wait_done("rdw", 50);
    check("rdw_size", {30'b0, last_size}, 32'h2);
    check("rdw_d_rd", d_rd, 32'h12345678);
    check("rdw_error", {31'b0, error}, 32'h0);
    paused_set = 1'b1;
    repeat (2) @(negedge clk);

    // MEM_WR_WORD misaligned
    wr0 = wr_cnt; ack_delay = 1;
    issue(4'hC, 32'h102, 32'h11112222);
    wait_done("mis", 20);
    check("mis_strobe", wr_cnt - wr0, 0);
    check("mis_error", {31'b0, error}, 32'h1);
    check("mis_d_rd", d_rd, 32'h0);
    check("mis_lat", busy_cycles, 2);

    // MEM_WR_BYTE 0x103
    wr0 = wr_cnt;
    issue(4'hD, 32'h103, 32'h00000055);
    wait_done("wrb", 20);
    check("wrb_strobe", wr_cnt - wr0, 1);
    check("wrb_wdata", last_wdata, 32'h55);
    check("wrb_d_rd", d_rd, 32'h55);
    check("wrb_error", {31'b0, error}, 32'h0);

    // REG_RD 0x25, never acknowledged
    ack_delay = 0;
    issue(4'h5, 32'h25, 32'h0);
    wait_done("tmo", 400);
    check("tmo_addr", last_addr, 32'h5);
    check("tmo_rf", {31'b0, last_rf}, 32'h1);
    check("tmo_error", {31'b0, error}, 32'h1);
    check("tmo_d_rd", d_rd, 32'h0);
    check("tmo_lat", busy_cycles, 256);

    // Ack in the last allowed cycle counts as success
    ack_delay = 254; ack_data = 32'h0BADBEEF;
    issue(4'h5, 32'h3, 32'h0);
    wait_done("edge_ok", 400);
    check("edge_ok_error", {31'b0, error}, 32'h0);
    check("edge_ok_d_rd", d_rd, 32'h0BADBEEF);
    check("edge_ok_lat", busy_cycles, 256);

    // Ack one cycle too late
    ack_delay = 255;
    issue(4'h5, 32'h3, 32'h0);
    wait_done("edge_late", 400);
    check("edge_late_error", {31'b0, error}, 32'h1);
    repeat (3) @(negedge clk);

    // MCU_RESET keeps pause
    rst0 = rst_cnt;
    issue(4'h3, 32'h0, 32'h0);
    wait_done("mrst", 20);
    check("mrst_pulse", rst_cnt - rst0, 1);
    check("mrst_pause", {31'b0, mcu_pause}, 32'h1);
    check("mrst_d_rd", d_rd, 32'h0);

    // Illegal command, then error cleared on the next accept
    issue(4'h7, 32'h0, 32'h0);
    wait_done("ill", 20);
    check("ill_error", {31'b0, error}, 32'h1);
    check("ill_d_rd", d_rd, 32'h0);
    issue(4'h4, 32'h0, 32'h0);
    check("ill_err_clear", {31'b0, error}, 32'h0);
    wait_done("status2", 20);

    // RESUME
    issue(4'h2, 32'h0, 32'h0);
    wait_done("res", 20);
    check("res_pause", {31'b0, mcu_pause}, 32'h0);
    check("res_d_rd", d_rd, 32'h0);
    paused_set = 1'b0;
    repeat (2) @(negedge clk);

    // REG_WR while the MCU runs
    wr0 = wr_cnt; ack_delay = 1; follow = 1'b1;
    issue(4'h6, 32'h1F, 32'hCAFEF00D);
    wait_done("rwr", 50);
`ifdef DB_AUTO_PAUSE_EN
    check("rwr_strobe", wr_cnt - wr0, 1);
    check("rwr_error", {31'b0, error}, 32'h0);
    check("rwr_pause", {31'b0, mcu_pause}, 32'h0);
    check("rwr_d_rd", d_rd, 32'hCAFEF00D);
`else
    check("rwr_strobe", wr_cnt - wr0, 0);
    check("rwr_error", {31'b0, error}, 32'h1);
    check("rwr_d_rd", d_rd, 32'h0);
`endif
    follow = 1'b0;
    paused_set = 1'b1;
    repeat (2) @(negedge clk);

    // Reset during S_ACK_WAIT
    issue(4'h1, 32'h0, 32'h0);
    wait_done("pause2", 20);
    ack_delay = 0;
    issue(4'h5, 32'h2, 32'h0);
    repeat (10) @(negedge clk);
    check("mid_busy_before", {31'b0, busy}, 32'h1);
    reset = 1'b0;
    #1;
    check("mid_busy", {31'b0, busy}, 32'h0);
    check("mid_pause", {31'b0, mcu_pause}, 32'h0);
    check("mid_error", {31'b0, error}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    issue(4'h4, 32'h0, 32'h0);
    check("post_rst_busy", {31'b0, busy}, 32'h1);
    wait_done("post_rst", 20);
    check("post_rst_d_rd", d_rd, 32'h1);
    check("post_rst_error", {31'b0, error}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
